// File: rtl/fps_monitor.sv
// Frame-rate monitor: counts VSYNC frame starts per CLK_FREQ_HZ-cycle window,
// measures the frame period in clocks and keeps a running frame total.
module fps_monitor #(
  parameter int unsigned CLK_FREQ_HZ       = 100000000,
  parameter int unsigned FPS_WIDTH         = 16,
  parameter bit          VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        frame_vsync,
  output logic [31:0] frames_per_second,
  output logic        fps_update,
  output logic [31:0] frame_period_clks,
  output logic [31:0] total_frame_count
);

  localparam int unsigned          TICK_W     = $clog2(CLK_FREQ_HZ);
  localparam logic [TICK_W-1:0]    TICK_LAST  = TICK_W'(CLK_FREQ_HZ - 1);
  localparam logic [FPS_WIDTH-1:0] FRAME_MAX  = '1;
  localparam logic                 VSYNC_IDLE = logic'(!VSYNC_ACTIVE_HIGH);

  typedef enum logic {
    DISABLED = 1'b0,
    RUN      = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   vsync_q;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [FPS_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]            period_cnt_q, period_cnt_d;
  logic                   period_valid_q, period_valid_d;
  logic [31:0]            fps_q, fps_d;
  logic                   fps_upd_q, fps_upd_d;
  logic [31:0]            period_out_q, period_out_d;
  logic [31:0]            total_q, total_d;

  logic                   frame_start;
  logic                   run;
  logic                   window_end;
  logic [FPS_WIDTH-1:0]   frame_inc;

  assign frame_start = VSYNC_ACTIVE_HIGH ? (frame_vsync & ~vsync_q)
                                         : (~frame_vsync & vsync_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISABLED: if (enable)  state_d = RUN;
      RUN:      if (!enable) state_d = DISABLED;
      default:                state_d = DISABLED;
    endcase
  end

  // The datapath follows the state being entered, so a window begins in the
  // very cycle enable is first seen high.
  assign run        = (state_d == RUN);
  assign window_end = (tick_q == TICK_LAST);
  assign frame_inc  = (frame_start && (frame_cnt_q != FRAME_MAX)) ?
                      frame_cnt_q + FPS_WIDTH'(1) : frame_cnt_q;

  always_comb begin
    tick_d         = tick_q;
    frame_cnt_d    = frame_cnt_q;
    period_cnt_d   = period_cnt_q;
    period_valid_d = period_valid_q;
    fps_d          = fps_q;
    fps_upd_d      = 1'b0;
    period_out_d   = period_out_q;
    total_d        = total_q;

    if (!run) begin
      tick_d         = '0;
      frame_cnt_d    = '0;
      period_cnt_d   = '0;
      period_valid_d = 1'b0;
    end else begin
      tick_d = window_end ? '0 : tick_q + TICK_W'(1);

      // A frame start on the closing cycle belongs to the closing window.
      if (window_end) begin
        fps_d       = 32'(frame_inc);
        frame_cnt_d = '0;
        fps_upd_d   = 1'b1;
      end else begin
        frame_cnt_d = frame_inc;
      end

      if (period_cnt_q != 32'hFFFF_FFFF) period_cnt_d = period_cnt_q + 32'd1;

      if (frame_start) begin
        if (period_valid_q) period_out_d = period_cnt_q;
        period_cnt_d   = 32'd1;
        period_valid_d = 1'b1;
        total_d        = total_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= DISABLED;
      vsync_q        <= VSYNC_IDLE;
      tick_q         <= '0;
      frame_cnt_q    <= '0;
      period_cnt_q   <= '0;
      period_valid_q <= 1'b0;
      fps_q          <= '0;
      fps_upd_q      <= 1'b0;
      period_out_q   <= '0;
      total_q        <= '0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= frame_vsync;
      tick_q         <= tick_d;
      frame_cnt_q    <= frame_cnt_d;
      period_cnt_q   <= period_cnt_d;
      period_valid_q <= period_valid_d;
      fps_q          <= fps_d;
      fps_upd_q      <= fps_upd_d;
      period_out_q   <= period_out_d;
      total_q        <= total_d;
    end
  end

  assign frames_per_second = fps_q;
  assign fps_update        = fps_upd_q;
  assign frame_period_clks = period_out_q;
  assign total_frame_count = total_q;

endmodule
